// File: rtl/fiber_pkg.sv
// Shared types and constants for the single-fiber value store.
// Token format: bit DATA_W is the control flag, the low DATA_W bits carry value/position.
package fiber_pkg;

  localparam int DATA_W  = 16;
  localparam int MEM_W   = 64;
  localparam int ADDR_W  = 9;
  localparam int LANES   = MEM_W / DATA_W;
  localparam int TOKEN_W = DATA_W + 1;
  localparam int CAP     = (1 << ADDR_W) * LANES;
  localparam int CNT_W   = ADDR_W + 3;

  localparam logic [TOKEN_W-1:0] DONE_TOKEN = 17'h10100;

  typedef enum logic {
    WRITE = 1'b0,
    READ  = 1'b1
  } state_t;

  function automatic logic is_ctrl(input logic [TOKEN_W-1:0] tok);
    return tok[TOKEN_W-1];
  endfunction

  function automatic logic is_done(input logic [TOKEN_W-1:0] tok);
    return (tok == DONE_TOKEN);
  endfunction

  function automatic logic [DATA_W-1:0] lane_of(input logic [MEM_W-1:0] word,
                                                input logic [1:0]       lane);
    logic [DATA_W-1:0] v;
    case (lane)
      2'd0:    v = word[0*DATA_W +: DATA_W];
      2'd1:    v = word[1*DATA_W +: DATA_W];
      2'd2:    v = word[2*DATA_W +: DATA_W];
      default: v = word[3*DATA_W +: DATA_W];
    endcase
    return v;
  endfunction

endpackage

// File: rtl/fiber_out_fifo.sv
// Two-entry token FIFO feeding rd_val; push/pop are honoured only while clk_en is high.
module fiber_out_fifo
  import fiber_pkg::*;
(
  input  logic               clk,
  input  logic               flush,
  input  logic               clk_en,
  input  logic               push,
  input  logic [TOKEN_W-1:0] push_data,
  input  logic               pop,
  output logic [TOKEN_W-1:0] head_data,
  output logic [1:0]         count
);

  logic [TOKEN_W-1:0] entry_q [2];
  logic [TOKEN_W-1:0] entry_d [2];
  logic               rd_ptr_q, rd_ptr_d;
  logic               wr_ptr_q, wr_ptr_d;
  logic [1:0]         count_q, count_d;
  logic               do_push, do_pop;

  always_comb begin
    entry_d  = entry_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    do_pop   = clk_en & pop & (count_q != 2'd0);
    do_push  = clk_en & push & ((count_q != 2'd2) | do_pop);
    if (do_push) begin
      entry_d[wr_ptr_q] = push_data;
      wr_ptr_d          = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      entry_q[0] <= '0;
      entry_q[1] <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else if (clk_en) begin
      entry_q    <= entry_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  assign head_data = entry_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/fiber_value_store.sv
// Single-fiber value buffer: packs a value stream into a 64-bit SRAM, then serves position lookups.
// Optional macro FIBER_PERF_CNT_EN adds wr_cycles/rd_cycles performance counters.
module fiber_value_store
  import fiber_pkg::*;
(
  input  logic               clk,
  input  logic               flush,
  input  logic               clk_en,
  input  logic               tile_en,
  input  logic [TOKEN_W-1:0] wr_data,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [TOKEN_W-1:0] rd_pos,
  input  logic               rd_pos_valid,
  output logic               rd_pos_ready,
  output logic [TOKEN_W-1:0] rd_val,
  output logic               rd_val_valid,
  input  logic               rd_val_ready,
  output logic [ADDR_W-1:0]  addr_to_mem,
  output logic [MEM_W-1:0]   data_to_mem,
  output logic               wen_to_mem,
  output logic               ren_to_mem,
  input  logic [MEM_W-1:0]   data_from_mem
`ifdef FIBER_PERF_CNT_EN
  ,
  output logic [31:0]        wr_cycles,
  output logic [31:0]        rd_cycles
`endif
);

  state_t                      state_q, state_d;
  logic [CNT_W-1:0]            wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]            len_q, len_d;
  logic [(LANES-1)*DATA_W-1:0] pack_q, pack_d;
  logic                        s1_valid_q, s1_valid_d;
  logic                        s1_mem_q, s1_mem_d;
  logic [1:0]                  s1_lane_q, s1_lane_d;
  logic [TOKEN_W-1:0]          s1_tok_q, s1_tok_d;

  logic                        wr_fire_s, rd_fire_s, pop_s, push_s;
  logic [TOKEN_W-1:0]          push_data_s, head_s;
  logic [1:0]                  fifo_count_s;
  logic [2:0]                  occupancy_s;
  logic                        mem_wen_s, mem_ren_s;
  logic [ADDR_W-1:0]           mem_addr_s;
  logic [MEM_W-1:0]            mem_wdata_s;

  assign wr_ready     = (state_q == WRITE) & tile_en;
  assign wr_fire_s    = wr_valid & wr_ready & clk_en;
  assign rd_val_valid = (fifo_count_s != 2'd0) & tile_en;
  assign pop_s        = rd_val_valid & rd_val_ready & clk_en;
  // Accept only if the FIFO can still absorb what stage-1 will hand it next cycle.
  assign occupancy_s  = {1'b0, fifo_count_s} + {2'b00, s1_valid_q} - {2'b00, pop_s};
  assign rd_pos_ready = (state_q == READ) & tile_en & clk_en & (occupancy_s <= 3'd1);
  assign rd_fire_s    = rd_pos_valid & rd_pos_ready;
  assign push_s       = s1_valid_q;
  assign push_data_s  = s1_mem_q ? {1'b0, lane_of(data_from_mem, s1_lane_q)} : s1_tok_q;
  assign rd_val       = head_s;

  // Next-state logic for the write packer, read stage-1 and the WRITE/READ FSM.
  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    len_d       = len_q;
    pack_d      = pack_q;
    s1_valid_d  = rd_fire_s;
    s1_mem_d    = s1_mem_q;
    s1_lane_d   = s1_lane_q;
    s1_tok_d    = s1_tok_q;
    mem_wen_s   = 1'b0;
    mem_ren_s   = 1'b0;
    mem_addr_s  = '0;
    mem_wdata_s = '0;

    if (wr_fire_s) begin
      if (!is_ctrl(wr_data)) begin
        if (wr_cnt_q < CNT_W'(CAP)) begin
          wr_cnt_d = wr_cnt_q + CNT_W'(1);
          case (wr_cnt_q[1:0])
            2'd0: pack_d[0*DATA_W +: DATA_W] = wr_data[DATA_W-1:0];
            2'd1: pack_d[1*DATA_W +: DATA_W] = wr_data[DATA_W-1:0];
            2'd2: pack_d[2*DATA_W +: DATA_W] = wr_data[DATA_W-1:0];
            default: begin
              mem_wen_s   = 1'b1;
              mem_addr_s  = wr_cnt_q[ADDR_W+1:2];
              mem_wdata_s = {wr_data[DATA_W-1:0], pack_q};
              pack_d      = '0;
            end
          endcase
        end else begin
          wr_cnt_d = wr_cnt_q;
        end
      end else if (is_done(wr_data)) begin
        // Lanes not yet filled are already zero: pack is cleared after every flushed word.
        if (wr_cnt_q[1:0] != 2'd0) begin
          mem_wen_s   = 1'b1;
          mem_addr_s  = wr_cnt_q[ADDR_W+1:2];
          mem_wdata_s = {{DATA_W{1'b0}}, pack_q};
        end else begin
          mem_wen_s   = 1'b0;
        end
        len_d   = wr_cnt_q;
        pack_d  = '0;
        state_d = READ;
      end else begin
        pack_d = pack_q;
      end
    end else begin
      pack_d = pack_q;
    end

    if (rd_fire_s) begin
      if (!is_ctrl(rd_pos)) begin
        s1_tok_d  = '0;
        s1_lane_d = rd_pos[1:0];
        if (rd_pos[DATA_W-1:0] < {{(DATA_W-CNT_W){1'b0}}, len_q}) begin
          mem_ren_s  = 1'b1;
          mem_addr_s = rd_pos[ADDR_W+1:2];
          s1_mem_d   = 1'b1;
        end else begin
          s1_mem_d   = 1'b0;
        end
      end else begin
        s1_mem_d = 1'b0;
        s1_tok_d = rd_pos;
        if (is_done(rd_pos)) begin
          state_d  = WRITE;
          wr_cnt_d = '0;
          len_d    = '0;
        end else begin
          state_d  = state_q;
        end
      end
    end else begin
      s1_mem_d = s1_mem_q;
    end
  end

  // State registers; flush returns to an empty WRITE state, clk_en low freezes everything.
  always_ff @(posedge clk) begin
    if (flush) begin
      state_q    <= WRITE;
      wr_cnt_q   <= '0;
      len_q      <= '0;
      pack_q     <= '0;
      s1_valid_q <= 1'b0;
      s1_mem_q   <= 1'b0;
      s1_lane_q  <= 2'd0;
      s1_tok_q   <= '0;
    end else if (clk_en) begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      len_q      <= len_d;
      pack_q     <= pack_d;
      s1_valid_q <= s1_valid_d;
      s1_mem_q   <= s1_mem_d;
      s1_lane_q  <= s1_lane_d;
      s1_tok_q   <= s1_tok_d;
    end
  end

  assign addr_to_mem = mem_addr_s;
  assign data_to_mem = mem_wdata_s;
  assign wen_to_mem  = mem_wen_s & tile_en;
  assign ren_to_mem  = mem_ren_s & tile_en;

  fiber_out_fifo u_out_fifo (
    .clk       (clk),
    .flush     (flush),
    .clk_en    (clk_en),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .head_data (head_s),
    .count     (fifo_count_s)
  );

`ifdef FIBER_PERF_CNT_EN
  logic [31:0] wr_cycles_q, wr_cycles_d;
  logic [31:0] rd_cycles_q, rd_cycles_d;
  logic        wr_active_q, wr_active_d;
  logic        rd_pending_q, rd_pending_d;

  // wr_active marks an in-progress write fiber; rd_pending covers DONE still travelling to rd_val.
  always_comb begin
    wr_cycles_d  = wr_cycles_q;
    rd_cycles_d  = rd_cycles_q;
    wr_active_d  = wr_active_q;
    rd_pending_d = rd_pending_q;
    if ((state_q == WRITE) && (wr_active_q || wr_valid)) begin
      wr_cycles_d = wr_cycles_q + 32'd1;
      wr_active_d = !(wr_fire_s && is_done(wr_data));
    end else begin
      wr_active_d = wr_active_q;
    end
    if ((state_q == READ) || rd_pending_q) begin
      rd_cycles_d = rd_cycles_q + 32'd1;
    end else begin
      rd_cycles_d = rd_cycles_q;
    end
    if (rd_fire_s && is_done(rd_pos)) begin
      rd_pending_d = 1'b1;
    end else if (pop_s && is_done(head_s)) begin
      rd_pending_d = 1'b0;
    end else begin
      rd_pending_d = rd_pending_q;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    if (flush) begin
      wr_cycles_q  <= 32'd0;
      rd_cycles_q  <= 32'd0;
      wr_active_q  <= 1'b0;
      rd_pending_q <= 1'b0;
    end else if (clk_en) begin
      wr_cycles_q  <= wr_cycles_d;
      rd_cycles_q  <= rd_cycles_d;
      wr_active_q  <= wr_active_d;
      rd_pending_q <= rd_pending_d;
    end
  end

  assign wr_cycles = wr_cycles_q;
  assign rd_cycles = rd_cycles_q;
`endif

endmodule

// File: tb/tb_fiber_value_store.sv
// Directed bench for fiber_value_store with a behavioural single-port SRAM model.
module tb_fiber_value_store;
  import fiber_pkg::*;

  logic               clk = 1'b0;
  logic               flush, clk_en, tile_en;
  logic [TOKEN_W-1:0] wr_data, rd_pos, rd_val;
  logic               wr_valid, wr_ready, rd_pos_valid, rd_pos_ready;
  logic               rd_val_valid, rd_val_ready;
  logic [ADDR_W-1:0]  addr_to_mem;
  logic [MEM_W-1:0]   data_to_mem, data_from_mem;
  logic               wen_to_mem, ren_to_mem;

  logic [MEM_W-1:0]   mem_model [1 << ADDR_W];
  logic [TOKEN_W-1:0] got_q [$];
  int                 ren_cnt = 0;
  int                 vectors = 0;
  int                 miscompares = 0;

  localparam logic [TOKEN_W-1:0] DONE = 17'h10100;

  always #5 clk = ~clk;

  fiber_value_store dut (
    .clk           (clk),
    .flush         (flush),
    .clk_en        (clk_en),
    .tile_en       (tile_en),
    .wr_data       (wr_data),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .rd_pos        (rd_pos),
    .rd_pos_valid  (rd_pos_valid),
    .rd_pos_ready  (rd_pos_ready),
    .rd_val        (rd_val),
    .rd_val_valid  (rd_val_valid),
    .rd_val_ready  (rd_val_ready),
    .addr_to_mem   (addr_to_mem),
    .data_to_mem   (data_to_mem),
    .wen_to_mem    (wen_to_mem),
    .ren_to_mem    (ren_to_mem),
    .data_from_mem (data_from_mem)
  );

  always @(posedge clk) begin
    if (wen_to_mem) mem_model[addr_to_mem] <= data_to_mem;
    if (ren_to_mem) data_from_mem <= mem_model[addr_to_mem];
  end

  always @(negedge clk) begin
    if (rd_val_valid && rd_val_ready && clk_en && !flush) got_q.push_back(rd_val);
    if (ren_to_mem) ren_cnt++;
  end

  task automatic send_wr(input logic [TOKEN_W-1:0] tok);
    bit ok = 1'b0;
    wr_data  = tok;
    wr_valid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      #1 ok = wr_ready;
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL wr_accept: token %h not accepted, required within 40 cycles", tok);
    end
  endtask

  task automatic send_rd(input logic [TOKEN_W-1:0] tok);
    bit ok = 1'b0;
    rd_pos       = tok;
    rd_pos_valid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      #1 ok = rd_pos_ready;
      @(posedge clk); #1;
    end
    rd_pos_valid = 1'b0;
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL rd_accept: pos %h not accepted, required within 40 cycles", tok);
    end
  endtask

  task automatic wait_out(input int n);
    for (int i = 0; i < 100 && got_q.size() < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_stream(input string name, input logic [TOKEN_W-1:0] exp [$]);
    vectors++;
    if (got_q.size() != exp.size()) begin
      miscompares++;
      $display("FAIL %s_count: got %0d tokens, required %0d", name, got_q.size(), exp.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      vectors++;
      if (i >= got_q.size()) begin
        miscompares++;
        $display("FAIL %s[%0d]: token missing, required %h", name, i, exp[i]);
      end else if (got_q[i] !== exp[i]) begin
        miscompares++;
        $display("FAIL %s[%0d]: got %h, required %h", name, i, got_q[i], exp[i]);
      end
    end
  endtask

  task automatic test_reset();
    flush = 1'b1; clk_en = 1'b1; tile_en = 1'b1;
    wr_valid = 1'b0; rd_pos_valid = 1'b0; rd_val_ready = 1'b1;
    wr_data = '0; rd_pos = '0;
    repeat (2) @(posedge clk);
    #1 flush = 1'b0;
    #1;
    vectors++; if (wr_ready !== 1'b1) begin miscompares++; $display("FAIL reset_wr_ready: got %b required 1", wr_ready); end
    vectors++; if (rd_pos_ready !== 1'b0) begin miscompares++; $display("FAIL reset_rd_pos_ready: got %b required 0", rd_pos_ready); end
    vectors++; if (rd_val_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rd_val_valid: got %b required 0", rd_val_valid); end
    vectors++; if (wen_to_mem !== 1'b0 || ren_to_mem !== 1'b0) begin miscompares++; $display("FAIL reset_mem_en: got wen=%b ren=%b required 0/0", wen_to_mem, ren_to_mem); end
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    got_q.delete();
    for (int v = 10; v <= 14; v++) send_wr(TOKEN_W'(v));
    send_wr(DONE);
    vectors++; if (mem_model[0] !== 64'h000D000C000B000A) begin miscompares++; $display("FAIL word0: got %h required 000d000c000b000a", mem_model[0]); end
    vectors++; if (mem_model[1] !== 64'h000000000000000E) begin miscompares++; $display("FAIL word1: got %h required 000000000000000e", mem_model[1]); end
    vectors++; if (wr_ready !== 1'b0) begin miscompares++; $display("FAIL read_wr_ready: got %b required 0", wr_ready); end
    send_rd(17'h00000); send_rd(17'h00004); send_rd(17'h00002);
    send_rd(17'h10000); send_rd(DONE);
    wait_out(5);
    check_stream("basic", '{17'h0000A, 17'h0000E, 17'h0000C, 17'h10000, 17'h10100});
  endtask

  task automatic test_second_fiber();
    got_q.delete();
    send_wr(17'h00001); send_wr(17'h00002); send_wr(DONE);
    vectors++; if (mem_model[0] !== 64'h0000000000020001) begin miscompares++; $display("FAIL second_word0: got %h required 0000000000020001", mem_model[0]); end
    send_rd(17'h00001); send_rd(DONE);
    wait_out(2);
    check_stream("second", '{17'h00002, 17'h10100});
  endtask

  task automatic test_out_of_range();
    int ren0;
    got_q.delete();
    send_wr(17'h00005); send_wr(17'h00006); send_wr(17'h00007); send_wr(DONE);
    ren0 = ren_cnt;
    send_rd(17'h00007);
    vectors++; if (rd_val_valid !== 1'b0) begin miscompares++; $display("FAIL latency_early: rd_val_valid %b required 0", rd_val_valid); end
    @(posedge clk); #1;
    vectors++; if (rd_val_valid !== 1'b1 || rd_val !== 17'h00000) begin miscompares++; $display("FAIL oor_value: got valid=%b val=%h required 1/00000", rd_val_valid, rd_val); end
    vectors++; if (ren_cnt != ren0) begin miscompares++; $display("FAIL oor_ren: got %0d reads required 0", ren_cnt - ren0); end
    send_rd(17'h00002); send_rd(DONE);
    wait_out(3);
    check_stream("oor", '{17'h00000, 17'h00007, 17'h10100});
  endtask

  task automatic test_pos_blocked_in_write();
    got_q.delete();
    rd_pos = 17'h00000; rd_pos_valid = 1'b1;
    repeat (3) begin
      #1;
      vectors++; if (rd_pos_ready !== 1'b0) begin miscompares++; $display("FAIL blocked_ready: got %b required 0", rd_pos_ready); end
      @(posedge clk); #1;
    end
    send_wr(17'h0002A);
    rd_pos_valid = 1'b1;
    send_wr(DONE);
    rd_pos_valid = 1'b1;
    #1;
    vectors++; if (rd_pos_ready !== 1'b1) begin miscompares++; $display("FAIL unblocked_ready: got %b required 1", rd_pos_ready); end
    @(posedge clk); #1;
    send_rd(DONE);
    wait_out(2);
    check_stream("blocked", '{17'h0002A, 17'h10100});
  endtask

  task automatic test_backpressure();
    int  k = 0;
    logic [TOKEN_W-1:0] exp [$];
    bit  acc;
    got_q.delete();
    for (int v = 100; v < 108; v++) send_wr(TOKEN_W'(v));
    send_wr(DONE);
    rd_val_ready = 1'b0;
    rd_pos = '0; rd_pos_valid = 1'b1;
    repeat (5) begin
      #1 acc = rd_pos_ready;
      @(posedge clk); #1;
      if (acc) begin k++; rd_pos = {1'b0, 16'(k)}; end
    end
    vectors++; if (k != 2) begin miscompares++; $display("FAIL stall_accepted: got %0d required 2", k); end
    #1;
    vectors++; if (rd_pos_ready !== 1'b0) begin miscompares++; $display("FAIL stall_ready: got %b required 0", rd_pos_ready); end
    vectors++; if (rd_val_valid !== 1'b1 || rd_val !== 17'd100) begin miscompares++; $display("FAIL stall_head: got valid=%b val=%h required 1/00064", rd_val_valid, rd_val); end
    rd_val_ready = 1'b1;
    for (int i = 0; i < 40 && k < 6; i++) begin
      #1 acc = rd_pos_ready;
      @(posedge clk); #1;
      if (acc) begin k++; rd_pos = {1'b0, 16'(k)}; end
    end
    rd_pos_valid = 1'b0;
    send_rd(DONE);
    wait_out(7);
    for (int v = 100; v < 106; v++) exp.push_back(TOKEN_W'(v));
    exp.push_back(DONE);
    check_stream("backpressure", exp);
  endtask

  task automatic test_flush();
    bit acc;
    got_q.delete();
    for (int v = 200; v < 204; v++) send_wr(TOKEN_W'(v));
    send_wr(DONE);
    rd_val_ready = 1'b0;
    rd_pos = 17'h00000; rd_pos_valid = 1'b1;
    repeat (3) begin
      #1 acc = rd_pos_ready;
      @(posedge clk); #1;
      if (acc) rd_pos = 17'h00001;
    end
    rd_pos_valid = 1'b0;
    vectors++; if (rd_val_valid !== 1'b1) begin miscompares++; $display("FAIL preflush_valid: got %b required 1", rd_val_valid); end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    vectors++; if (rd_val_valid !== 1'b0) begin miscompares++; $display("FAIL flush_valid: got %b required 0", rd_val_valid); end
    vectors++; if (wr_ready !== 1'b1) begin miscompares++; $display("FAIL flush_wr_ready: got %b required 1", wr_ready); end
    rd_val_ready = 1'b1;
    got_q.delete();
    send_wr(17'h00009); send_wr(DONE);
    vectors++; if (mem_model[0] !== 64'h0000000000000009) begin miscompares++; $display("FAIL flush_word0: got %h required 0000000000000009", mem_model[0]); end
    send_rd(17'h00000); send_rd(DONE);
    wait_out(2);
    @(posedge clk); #1;
    check_stream("after_flush", '{17'h00009, 17'h10100});
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_second_fiber();
    test_out_of_range();
    test_pos_blocked_in_write();
    test_backpressure();
    test_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
